// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm event reporter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alarm_pkg;

    localparam int NUM_ZONES = 3;
    localparam logic [1:0] EVT_TAG = 2'b10;

    localparam int EVT_ZONE_LSB = 0;
    localparam int EVT_SEQ_LSB  = 3;
    localparam int EVT_TAG_LSB  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] make_evt(input logic [2:0] seq,
                                            input logic [NUM_ZONES-1:0] zones);
        logic [7:0] b;
        b = '0;
        b[EVT_TAG_LSB  +: 2]         = EVT_TAG;
        b[EVT_SEQ_LSB  +: 3]         = seq;
        b[EVT_ZONE_LSB +: NUM_ZONES] = zones;
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: one byte per load, LSB first, CLKS_PER_BIT clocks per bit.
// Latency: tx falls on the edge that accepts load; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: rdy high in IDLE and in the last stop-bit cycle; load ignored otherwise.
module uart_tx_core
    import alarm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       rdy,
    output logic       busy,
    output logic       tx
);

    localparam logic [11:0] BAUD_LAST = 12'(CLKS_PER_BIT - 1);

    tx_state_t   state_q, state_d;
    logic [11:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_d, busy_d;
    logic        bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    // A queued byte is taken at the end of the stop bit so the next start bit
    // follows without an idle cycle in between.
    assign rdy = (state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 12'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx;
        busy_d  = busy;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (load) begin
                    state_d = ST_START;
                    shreg_d = data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (load) begin
                        state_d = ST_START;
                        shreg_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: rtl/alarm_event_tx.sv
// Zone-trip event reporter: baseline compare, one-shot per zone, one UART frame per event.
// Latency: zone change sampled at edge k -> tx falls at edge k+3.
// Backpressure: single pending slot; events arriving while full merge into it and set overflow.
module alarm_event_tx
    import alarm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_ZONES-1:0] zone_in,
    input  logic                 snap,
    input  logic                 armed,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow
);

    logic [NUM_ZONES-1:0] zs_meta, zs;
    logic [NUM_ZONES-1:0] baseline, reported, new_z;
    logic [2:0]           seq;
    logic                 pend_vld;
    logic [7:0]           pend_dat;
    logic                 core_rdy;
    logic                 take, evt, slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zs_meta <= '0;
            zs      <= '0;
        end else begin
            zs_meta <= zone_in;
            zs      <= zs_meta;
        end
    end

    assign new_z     = armed ? ((zs ^ baseline) & ~reported) : '0;
    // A snap in the same cycle as a detection suppresses the event.
    assign evt       = (|new_z) & ~snap;
    assign take      = pend_vld & core_rdy;
    assign slot_free = ~pend_vld | take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baseline <= '0;
            reported <= '0;
        end else if (snap) begin
            baseline <= zs;
            reported <= '0;
        end else if (!armed) begin
            reported <= '0;
        end else begin
            reported <= reported | new_z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_dat <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else if (evt && slot_free) begin
            pend_vld <= 1'b1;
            pend_dat <= make_evt(seq, new_z);
            seq      <= seq + 3'd1;
        end else if (evt) begin
            pend_dat[EVT_ZONE_LSB +: NUM_ZONES] <= pend_dat[EVT_ZONE_LSB +: NUM_ZONES] | new_z;
            overflow <= 1'b1;
        end else if (take) begin
            pend_vld <= 1'b0;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pend_vld),
        .data  (pend_dat),
        .rdy   (core_rdy),
        .busy  (busy),
        .tx    (tx)
    );

endmodule
